// File: rtl/sram22_pkg.sv
// Shared constants and request type for the SRAM22 256x64 macro front-end.
package sram22_pkg;

   localparam int unsigned SRAM22_ADDR_WIDTH  = 8;
   localparam int unsigned SRAM22_DATA_WIDTH  = 64;
   localparam int unsigned SRAM22_WMASK_WIDTH = SRAM22_DATA_WIDTH / 8;

   typedef struct packed {
      logic                          we;
      logic [SRAM22_WMASK_WIDTH-1:0] wmask;
      logic [SRAM22_ADDR_WIDTH-1:0]  addr;
      logic [SRAM22_DATA_WIDTH-1:0]  din;
   } sram22_req_t;

   // Reads must never present a live byte mask to the macro.
   function automatic logic [SRAM22_WMASK_WIDTH-1:0] f_pin_wmask(
      input logic                          we,
      input logic [SRAM22_WMASK_WIDTH-1:0] wmask
   );
      return we ? wmask : '0;
   endfunction

endpackage

// File: rtl/sram22_rv_frontend_if.sv
// Request/response ready-valid bundle between a client and the SRAM22 front-end.
interface sram22_rv_frontend_if
   import sram22_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = SRAM22_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = SRAM22_DATA_WIDTH,
   parameter int unsigned WMASK_WIDTH = SRAM22_WMASK_WIDTH
) ();

   logic                   req_valid;
   logic                   req_ready;
   logic                   req_we;
   logic [WMASK_WIDTH-1:0] req_wmask;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic [DATA_WIDTH-1:0]  req_din;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DATA_WIDTH-1:0]  rsp_dout;

   modport master (
      output req_valid, req_we, req_wmask, req_addr, req_din, rsp_ready,
      input  req_ready, rsp_valid, rsp_dout
   );

   modport slave (
      input  req_valid, req_we, req_wmask, req_addr, req_din, rsp_ready,
      output req_ready, rsp_valid, rsp_dout
   );

endinterface

// File: rtl/sram22_rsp_fifo.sv
// Small circular response buffer; depth need not be a power of two.
module sram22_rsp_fifo #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned RSP_DEPTH  = 2,
   localparam int unsigned PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1,
   localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic [CNT_W-1:0]      o_count,
   output logic                  o_empty,
   output logic                  o_full
);

   logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_push;
   logic                  w_pop;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RSP_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(RSP_DEPTH));
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/sram22_rv_frontend.sv
// Ready/valid front-end for a 256x64 SRAM22 macro: drives the macro pins and
// queues registered read data so a stalled consumer never loses a beat.
module sram22_rv_frontend
   import sram22_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = SRAM22_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = SRAM22_DATA_WIDTH,
   parameter int unsigned WMASK_WIDTH = SRAM22_WMASK_WIDTH,
   parameter int unsigned RSP_DEPTH   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   sram22_rv_frontend_if.slave    bus,
   output logic                   o_sram_rstb,
   output logic                   o_sram_ce,
   output logic                   o_sram_we,
   output logic [WMASK_WIDTH-1:0] o_sram_wmask,
   output logic [ADDR_WIDTH-1:0]  o_sram_addr,
   output logic [DATA_WIDTH-1:0]  o_sram_din,
   input  logic [DATA_WIDTH-1:0]  i_sram_dout
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

   sram22_req_t           w_req;
   logic                  r_rd_inflight;
   logic [CNT_W-1:0]      w_fifo_count;
   logic [CNT_W-1:0]      w_occ;
   logic [DATA_WIDTH-1:0] w_fifo_head;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic                  w_fire;
   logic                  w_rsp_valid;
   logic                  w_push;
   logic                  w_pop;

   assign w_req = '{we: bus.req_we, wmask: bus.req_wmask, addr: bus.req_addr, din: bus.req_din};

   // Credits use registered state only, so a same-cycle pop frees nothing yet.
   assign w_occ         = w_fifo_count + CNT_W'(r_rd_inflight);
   assign bus.req_ready = !rst && (w_req.we || (w_occ < CNT_W'(RSP_DEPTH)));
   assign w_fire        = bus.req_valid && bus.req_ready;

   assign o_sram_rstb  = ~rst;
   assign o_sram_ce    = w_fire;
   assign o_sram_we    = w_req.we;
   assign o_sram_wmask = f_pin_wmask(w_req.we, w_req.wmask);
   assign o_sram_addr  = w_req.addr;
   assign o_sram_din   = w_req.din;

   always_ff @(posedge clk) begin
      if (rst) r_rd_inflight <= 1'b0;
      else     r_rd_inflight <= w_fire && !w_req.we;
   end

   // Fresh macro data bypasses an empty FIFO; otherwise it queues behind the head.
   assign w_rsp_valid  = !rst && (!w_fifo_empty || r_rd_inflight);
   assign w_pop        = !rst && !w_fifo_empty && bus.rsp_ready;
   assign w_push       = !rst && r_rd_inflight && (!w_fifo_empty || !bus.rsp_ready);
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_dout  = !w_rsp_valid ? '0 : (w_fifo_empty ? i_sram_dout : w_fifo_head);

   sram22_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .RSP_DEPTH  (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (i_sram_dout),
      .i_pop       (w_pop),
      .o_head      (w_fifo_head),
      .o_count     (w_fifo_count),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full)
   );

   logic w_unused;
   assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_sram22_rv_frontend.sv
// Bench: behavioural macro, queue-based response model checked every cycle,
// directed literal scenarios followed by randomized traffic.
module tb_sram22_rv_frontend;
   import sram22_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        sram_rstb, sram_ce, sram_we;
   logic [7:0]  sram_wmask, sram_addr;
   logic [63:0] sram_din;
   logic [63:0] sram_dout = '0;

   always #5 clk = ~clk;

   sram22_rv_frontend_if #() bus_if ();

   sram22_rv_frontend #(
      .RSP_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus_if.slave),
      .o_sram_rstb  (sram_rstb),
      .o_sram_ce    (sram_ce),
      .o_sram_we    (sram_we),
      .o_sram_wmask (sram_wmask),
      .o_sram_addr  (sram_addr),
      .o_sram_din   (sram_din),
      .i_sram_dout  (sram_dout)
   );

   // Macro: masked write, registered read data held until the next read.
   logic [63:0] mac_mem [256] = '{default: '0};
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) begin
            for (int b = 0; b < 8; b++)
               if (sram_wmask[b]) mac_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
         end else begin
            sram_dout <= mac_mem[sram_addr];
         end
      end
   end

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         if (n_fails <= 40)
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: every accepted but unconsumed read is one queue entry (= credits used).
   typedef struct {
      logic [63:0] data;
      int unsigned avail;
   } exp_t;

   exp_t        q[$];
   logic [63:0] ref_mem [256] = '{default: '0};
   int unsigned cyc = 0;
   logic        m_vis, m_ready, m_fire;
   logic [63:0] m_dout;

   initial begin
      forever begin
         @(negedge clk);
         m_vis   = !rst && (q.size() > 0) && (q[0].avail <= cyc);
         m_dout  = m_vis ? q[0].data : 64'h0;
         m_ready = !rst && (bus_if.req_we || (q.size() < DEPTH));
         m_fire  = bus_if.req_valid && m_ready;
         check("rsp_valid", bus_if.rsp_valid, m_vis);
         check("rsp_dout", bus_if.rsp_dout, m_dout);
         check("req_ready", bus_if.req_ready, m_ready);
         check("sram_ce", sram_ce, m_fire);
         check("sram_rstb", sram_rstb, !rst);
         check("sram_we", sram_we, bus_if.req_we);
         check("sram_wmask", sram_wmask, bus_if.req_we ? bus_if.req_wmask : 8'h00);
         check("sram_addr", sram_addr, bus_if.req_addr);
         check("sram_din", sram_din, bus_if.req_din);
         check("fifo_bound", (dut.u_rsp_fifo.o_count <= DEPTH), 1'b1);
         if (rst) begin
            q.delete();
         end else begin
            if (m_vis && bus_if.rsp_ready) void'(q.pop_front());
            if (m_fire) begin
               if (bus_if.req_we) begin
                  for (int b = 0; b < 8; b++)
                     if (bus_if.req_wmask[b])
                        ref_mem[bus_if.req_addr][b*8 +: 8] = bus_if.req_din[b*8 +: 8];
               end else begin
                  q.push_back('{data: ref_mem[bus_if.req_addr], avail: cyc + 1});
               end
            end
         end
         cyc++;
      end
   end

   logic [63:0] got[$];

   task automatic set_req(input logic v, input logic we, input logic [7:0] m,
                          input logic [7:0] a, input logic [63:0] d);
      bus_if.req_valid = v;
      bus_if.req_we    = we;
      bus_if.req_wmask = m;
      bus_if.req_addr  = a;
      bus_if.req_din   = d;
   endtask

   task automatic do_req(input logic we, input logic [7:0] m, input logic [7:0] a,
                         input logic [63:0] d);
      bit ok = 0;
      set_req(1'b1, we, m, a, d);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus_if.req_ready) begin
            ok = 1;
            @(posedge clk);
            #1;
         end
      end
      bus_if.req_valid = 1'b0;
      check("req_accept", ok, 1'b1);
   endtask

   task automatic read_and_check(input logic [7:0] a, input logic [63:0] exp, input string name);
      set_req(1'b1, 1'b0, 8'hFF, a, 64'h0);
      @(negedge clk);
      check({name, "_ready"}, bus_if.req_ready, 1'b1);
      check({name, "_early"}, bus_if.rsp_valid, 1'b0);
      @(posedge clk);
      #1 bus_if.req_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, bus_if.rsp_valid, 1'b1);
      check({name, "_dout"}, bus_if.rsp_dout, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input int n);
      bit acc;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus_if.rsp_valid && bus_if.rsp_ready) got.push_back(bus_if.rsp_dout);
         acc = bus_if.req_valid && bus_if.req_ready;
         @(posedge clk);
         #1;
         if (acc) bus_if.req_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst = 1'b1;
      set_req(1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
      bus_if.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Full write then masked byte-0 update, each read back with latency 1.
      do_req(1'b1, 8'hFF, 8'd5, 64'h0123456789ABCDEF);
      read_and_check(8'd5, 64'h0123456789ABCDEF, "t1");
      do_req(1'b1, 8'h01, 8'd5, 64'h00000000000000FF);
      read_and_check(8'd5, 64'h0123456789ABCDFF, "t2");

      // Stalled consumer: third read must wait for a credit, order preserved.
      do_req(1'b1, 8'hFF, 8'd1, 64'hA1A1_0000_0000_0001);
      do_req(1'b1, 8'hFF, 8'd2, 64'hA2A2_0000_0000_0002);
      do_req(1'b1, 8'hFF, 8'd3, 64'hA3A3_0000_0000_0003);
      bus_if.rsp_ready = 1'b0;
      set_req(1'b1, 1'b0, 8'h00, 8'd1, 64'h0);
      @(negedge clk) check("t3_rd1_ready", bus_if.req_ready, 1'b1);
      @(posedge clk) #1 bus_if.req_addr = 8'd2;
      @(negedge clk) check("t3_rd2_ready", bus_if.req_ready, 1'b1);
      @(posedge clk) #1 bus_if.req_addr = 8'd3;
      @(negedge clk) check("t3_rd3_stall", bus_if.req_ready, 1'b0);
      @(posedge clk);
      @(negedge clk) check("t3_rd3_stall2", bus_if.req_ready, 1'b0);
      @(posedge clk) #1 bus_if.rsp_ready = 1'b1;
      got.delete();
      collect(12);
      check("t3_count", got.size(), 3);
      check("t3_first", got[0], 64'hA1A1_0000_0000_0001);
      check("t3_second", got[1], 64'hA2A2_0000_0000_0002);
      check("t3_third", got[2], 64'hA3A3_0000_0000_0003);

      // Streaming reads: one accept and one response per cycle.
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         set_req(1'b1, 1'b0, 8'h00, 8'(i), 64'h0);
         @(negedge clk);
         check("t4_ready", bus_if.req_ready, 1'b1);
         if (bus_if.rsp_valid) seen++;
         @(posedge clk);
         #1;
      end
      bus_if.req_valid = 1'b0;
      @(negedge clk) if (bus_if.rsp_valid) seen++;
      check("t4_rsps", seen, 16);
      @(posedge clk) #1;

      // Writes accepted while the response side is full.
      bus_if.rsp_ready = 1'b0;
      do_req(1'b0, 8'h00, 8'd1, 64'h0);
      do_req(1'b0, 8'h00, 8'd2, 64'h0);
      set_req(1'b1, 1'b1, 8'hFF, 8'd9, 64'hDEAD_BEEF_0000_0009);
      @(negedge clk);
      check("t5_wr_ready", bus_if.req_ready, 1'b1);
      check("t5_wr_ce", sram_ce, 1'b1);
      check("t5_head", bus_if.rsp_dout, 64'hA1A1_0000_0000_0001);
      @(posedge clk) #1 bus_if.req_valid = 1'b0;
      bus_if.rsp_ready = 1'b1;
      got.delete();
      collect(6);
      check("t5_count", got.size(), 2);
      check("t5_first", got[0], 64'hA1A1_0000_0000_0001);
      check("t5_second", got[1], 64'hA2A2_0000_0000_0002);

      // Reset with one entry queued and one read in flight.
      bus_if.rsp_ready = 1'b0;
      do_req(1'b0, 8'h00, 8'd1, 64'h0);
      set_req(1'b1, 1'b0, 8'h00, 8'd2, 64'h0);
      @(negedge clk) check("t6_rd2_ready", bus_if.req_ready, 1'b1);
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("t6_rstb", sram_rstb, 1'b0);
      check("t6_valid", bus_if.rsp_valid, 1'b0);
      check("t6_ready", bus_if.req_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_if.rsp_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk) if (bus_if.rsp_valid) seen++;
      end
      check("t6_no_stale", seen, 0);
      @(posedge clk) #1;

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         set_req($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4, 8'($urandom),
                 8'($urandom_range(0, 15)), {$urandom, $urandom});
         bus_if.rsp_ready = $urandom_range(0, 9) < 7;
         rst = ($urandom_range(0, 63) == 0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      bus_if.req_valid = 1'b0;
      bus_if.rsp_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
